uart_cmd_if: RTL and testbench



---
 rtl/uart_cmd_if.sv | 185 ++++++++++++++++++
 tb/tb_uart_cmd_if.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_if.sv
// 8N1 UART front end: byte pairs from RX become a 16-bit cmd (cmd_rdy ~BAUD_DIV/2+9*BAUD_DIV+3 clocks after the 2nd start edge);
// resp bytes are serialised on TX. There is no backpressure: cmd_rdy is a level the consumer clears, and send_resp is ignored while busy.
module uart_cmd_if #(
  parameter int BAUD_DIV = 2604,
  parameter int CNT_W    = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic        TX,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp,
  input  logic        send_resp,
  output logic        resp_sent
);

  localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(BAUD_DIV / 2);
  localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(BAUD_DIV);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA} rx_state_t;
  typedef enum logic       {WAIT_HI, WAIT_LO}           asm_state_t;
  typedef enum logic       {TX_IDLE, TX_XMIT}           tx_state_t;

  logic             rx_s1_q, rx_s2_q, rx_s3_q;
  rx_state_t        rx_st_q;
  logic [CNT_W-1:0] rx_cnt_q;
  logic [3:0]       rx_bit_q;
  logic [7:0]       rx_sh_q;
  logic             rx_fall, rx_tick, rx_go, rx_done;

  asm_state_t       asm_q, asm_d;
  logic [15:0]      cmd_q, cmd_d;
  logic             cmd_rdy_q, cmd_rdy_d;

  tx_state_t        tx_st_q;
  logic [9:0]       tx_sh_q;
  logic [CNT_W-1:0] tx_cnt_q;
  logic [3:0]       tx_bit_q;
  logic             tx_q;
  logic             resp_sent_q;

  // s3 is only a delayed copy of the synchronised line, used for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
      rx_s3_q <= 1'b1;
    end else begin
      rx_s1_q <= RX;
      rx_s2_q <= rx_s1_q;
      rx_s3_q <= rx_s2_q;
    end
  end

  assign rx_fall = rx_s3_q & ~rx_s2_q;
  assign rx_tick = (rx_cnt_q == ONE);
  assign rx_go   = (rx_st_q == RX_START) && rx_tick && !rx_s2_q;
  assign rx_done = (rx_st_q == RX_DATA) && rx_tick && (rx_bit_q == 4'd8);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_st_q  <= RX_IDLE;
      rx_cnt_q <= '0;
      rx_bit_q <= '0;
      rx_sh_q  <= '0;
    end else begin
      case (rx_st_q)
        RX_IDLE: begin
          if (rx_fall) begin
            rx_st_q  <= RX_START;
            rx_cnt_q <= HALF_BIT;
          end
        end
        RX_START: begin
          if (rx_tick) begin
            if (rx_s2_q) begin
              rx_st_q <= RX_IDLE;
            end else begin
              rx_st_q  <= RX_DATA;
              rx_cnt_q <= FULL_BIT;
              rx_bit_q <= '0;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q - ONE;
          end
        end
        RX_DATA: begin
          if (rx_tick) begin
            rx_cnt_q <= FULL_BIT;
            // The ninth sample is the stop bit; its value is deliberately ignored.
            if (rx_bit_q == 4'd8) begin
              rx_st_q <= RX_IDLE;
            end else begin
              rx_sh_q  <= {rx_s2_q, rx_sh_q[7:1]};
              rx_bit_q <= rx_bit_q + 4'd1;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q - ONE;
          end
        end
        default: rx_st_q <= RX_IDLE;
      endcase
    end
  end

  // A new frame starting clears cmd_rdy so the high byte never changes under a valid cmd; a set beats a clear.
  always_comb begin
    asm_d     = asm_q;
    cmd_d     = cmd_q;
    cmd_rdy_d = cmd_rdy_q;
    if (rx_go || clr_cmd_rdy) cmd_rdy_d = 1'b0;
    if (rx_done) begin
      if (asm_q == WAIT_HI) begin
        cmd_d[15:8] = rx_sh_q;
        asm_d       = WAIT_LO;
      end else begin
        cmd_d[7:0]  = rx_sh_q;
        cmd_rdy_d   = 1'b1;
        asm_d       = WAIT_HI;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      asm_q     <= WAIT_HI;
      cmd_q     <= '0;
      cmd_rdy_q <= 1'b0;
    end else begin
      asm_q     <= asm_d;
      cmd_q     <= cmd_d;
      cmd_rdy_q <= cmd_rdy_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_st_q     <= TX_IDLE;
      tx_sh_q     <= '1;
      tx_cnt_q    <= '0;
      tx_bit_q    <= '0;
      tx_q        <= 1'b1;
      resp_sent_q <= 1'b0;
    end else begin
      case (tx_st_q)
        TX_IDLE: begin
          if (send_resp) begin
            tx_sh_q     <= {1'b1, resp, 1'b0};
            tx_q        <= 1'b0;
            tx_cnt_q    <= FULL_BIT;
            tx_bit_q    <= '0;
            resp_sent_q <= 1'b0;
            tx_st_q     <= TX_XMIT;
          end
        end
        TX_XMIT: begin
          if (tx_cnt_q == ONE) begin
            tx_cnt_q <= FULL_BIT;
            if (tx_bit_q == 4'd9) begin
              tx_q        <= 1'b1;
              resp_sent_q <= 1'b1;
              tx_st_q     <= TX_IDLE;
            end else begin
              tx_sh_q  <= {tx_sh_q[0], tx_sh_q[9:1]};
              tx_q     <= tx_sh_q[1];
              tx_bit_q <= tx_bit_q + 4'd1;
            end
          end else begin
            tx_cnt_q <= tx_cnt_q - ONE;
          end
        end
        default: tx_st_q <= TX_IDLE;
      endcase
    end
  end

  assign TX        = tx_q;
  assign cmd       = cmd_q;
  assign cmd_rdy   = cmd_rdy_q;
  assign resp_sent = resp_sent_q;

endmodule

// File: tb/tb_uart_cmd_if.sv
// Directed bench for uart_cmd_if at BAUD_DIV=16; inputs change and outputs are sampled on the falling clock edge.
module tb_uart_cmd_if;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        RX;
  logic        TX;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic [7:0]  resp;
  logic        send_resp;
  logic        resp_sent;

  int total = 0;
  int bad   = 0;

  logic [9:0] frame;
  logic [9:0] txcap;
  logic       rs_at_accept;

  uart_cmd_if #(.BAUD_DIV(16), .CNT_W(12)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .RX          (RX),
    .TX          (TX),
    .cmd         (cmd),
    .cmd_rdy     (cmd_rdy),
    .clr_cmd_rdy (clr_cmd_rdy),
    .resp        (resp),
    .send_resp   (send_resp),
    .resp_sent   (resp_sent)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives start + 8 data bits, then leaves RX high and returns at the stop-bit midpoint.
  task automatic rx_bits(input logic [7:0] b);
    RX = 1'b0;
    wait_neg(16);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      wait_neg(16);
    end
    RX = 1'b1;
    wait_neg(8);
  endtask

  initial begin
    rst_n = 1'b0; RX = 1'b1; clr_cmd_rdy = 1'b0; resp = 8'h00; send_resp = 1'b0;
    wait_neg(3);
    check("rst_tx", 16'(TX), 16'h1);
    check("rst_cmd", cmd, 16'h0000);
    check("rst_rdy", 16'(cmd_rdy), 16'h0);
    check("rst_sent", 16'(resp_sent), 16'h0);
    rst_n = 1'b1;
    wait_neg(500);
    check("idle_tx", 16'(TX), 16'h1);
    check("idle_cmd", cmd, 16'h0000);
    check("idle_rdy", 16'(cmd_rdy), 16'h0);
    check("idle_sent", 16'(resp_sent), 16'h0);

    // Command 0x47, 0xAA
    rx_bits(8'h47);
    wait_neg(8);
    check("hi_only_cmd", cmd, 16'h4700);
    check("hi_only_rdy", 16'(cmd_rdy), 16'h0);
    rx_bits(8'hAA);
    check("rdy_not_early", 16'(cmd_rdy), 16'h0);
    wait_neg(3);
    check("rdy_set", 16'(cmd_rdy), 16'h1);
    check("cmd_47aa", cmd, 16'h47AA);
    wait_neg(100);
    check("rdy_held", 16'(cmd_rdy), 16'h1);
    clr_cmd_rdy = 1'b1;
    wait_neg(1);
    clr_cmd_rdy = 1'b0;
    check("rdy_cleared", 16'(cmd_rdy), 16'h0);
    check("cmd_kept", cmd, 16'h47AA);

    // Response 0xA5, with an ignored second request during bit 4
    frame = {1'b1, 8'hA5, 1'b0};
    resp = 8'hA5; send_resp = 1'b1;
    wait_neg(1);
    send_resp = 1'b0; resp = 8'h00;
    for (int j = 0; j < 160; j++) begin
      check($sformatf("tx_bit%0d_clk%0d", j / 16, j % 16), 16'(TX), 16'(frame[j / 16]));
      check("sent_low_busy", 16'(resp_sent), 16'h0);
      if (j == 64) begin send_resp = 1'b1; resp = 8'hFF; end
      if (j == 65) begin send_resp = 1'b0; resp = 8'h00; end
      wait_neg(1);
    end
    check("sent_high", 16'(resp_sent), 16'h1);
    check("tx_idle_after", 16'(TX), 16'h1);
    wait_neg(200);
    check("sent_level", 16'(resp_sent), 16'h1);
    check("tx_no_restart", 16'(TX), 16'h1);

    // Glitch then 0x81, 0x02
    RX = 1'b0;
    wait_neg(4);
    RX = 1'b1;
    wait_neg(100);
    check("glitch_cmd", cmd, 16'h47AA);
    check("glitch_rdy", 16'(cmd_rdy), 16'h0);
    rx_bits(8'h81);
    wait_neg(8);
    rx_bits(8'h02);
    wait_neg(3);
    check("cmd_8102", cmd, 16'h8102);
    check("rdy_8102", 16'(cmd_rdy), 16'h1);
    wait_neg(5);

    // Full duplex: RX 0x01,0x02 with a same-cycle clear, while TX sends 0x3C
    resp = 8'h3C; send_resp = 1'b1;
    fork
      begin
        wait_neg(1);
        rx_bits(8'h01);
        wait_neg(8);
        check("start_clears_rdy", 16'(cmd_rdy), 16'h0);
        check("dup_hi_cmd", cmd, 16'h0102);
        rx_bits(8'h02);
        wait_neg(2);
        clr_cmd_rdy = 1'b1;
        wait_neg(1);
        clr_cmd_rdy = 1'b0;
        check("set_beats_clr", 16'(cmd_rdy), 16'h1);
        wait_neg(1);
        check("set_beats_clr_held", 16'(cmd_rdy), 16'h1);
        check("dup_cmd", cmd, 16'h0102);
      end
      begin
        wait_neg(1);
        send_resp = 1'b0; resp = 8'h00;
        rs_at_accept = resp_sent;
        wait_neg(8);
        for (int k = 0; k < 10; k++) begin
          txcap[k] = TX;
          wait_neg(16);
        end
      end
    join
    check("dup_sent_cleared", 16'(rs_at_accept), 16'h0);
    check("dup_tx_frame", 16'(txcap), 16'h0278);
    check("dup_sent", 16'(resp_sent), 16'h1);

    // Reset during TX bit 4 (a 0 bit of 0xA5)
    resp = 8'hA5; send_resp = 1'b1;
    wait_neg(1);
    send_resp = 1'b0;
    wait_neg(72);
    check("tx_bit4_pre_rst", 16'(TX), 16'h0);
    #2 rst_n = 1'b0;
    #1;
    check("tx_async_rst", 16'(TX), 16'h1);
    check("sent_async_rst", 16'(resp_sent), 16'h0);
    check("rdy_async_rst", 16'(cmd_rdy), 16'h0);
    wait_neg(2);
    rst_n = 1'b1;
    wait_neg(50);
    check("tx_stays_idle", 16'(TX), 16'h1);

    // Reset after one RX byte, then a fresh pair
    rx_bits(8'h99);
    wait_neg(8);
    check("half_cmd", cmd, 16'h9900);
    rst_n = 1'b0;
    wait_neg(3);
    check("half_cmd_rst", cmd, 16'h0000);
    rst_n = 1'b1;
    wait_neg(20);
    rx_bits(8'h12);
    wait_neg(8);
    check("realign_rdy_lo", 16'(cmd_rdy), 16'h0);
    rx_bits(8'h34);
    wait_neg(3);
    check("realign_cmd", cmd, 16'h1234);
    check("realign_rdy", 16'(cmd_rdy), 16'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
